// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the 5-stage core.
// Decodes the IF/ID opcode into EX/M/WB control groups and carries them,
// with the destination register, through ID/EX, EX/MEM and MEM/WB.
// Also detects load-use hazards (stall plus bubble) and resolves branches
// in MEM (flush of IF/ID, ID/EX and EX/MEM).
module ctrl_pipe #(
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit HAZARD_EN      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [OPCODE_WIDTH-1:0]   id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      mem_zero,
    output logic                      ex_reg_dst,
    output logic                      ex_alu_src,
    output logic [1:0]                ex_alu_op,
    output logic                      mem_branch,
    output logic                      mem_branch_ne,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      wb_reg_src,
    output logic                      wb_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] ex_wreg,
    output logic [REG_ADDR_WIDTH-1:0] mem_wreg,
    output logic [REG_ADDR_WIDTH-1:0] wb_wreg,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      ifid_flush,
    output logic                      branch_taken
);

    localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'h04);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(6'h05);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'h08);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'h23);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'h2B);

    typedef struct packed {
        logic                      reg_dst;
        logic                      alu_src;
        logic [1:0]                alu_op;
        logic                      branch;
        logic                      branch_ne;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_src;
        logic                      reg_write;
        logic [REG_ADDR_WIDTH-1:0] wreg;
    } idex_t;

    typedef struct packed {
        logic                      branch;
        logic                      branch_ne;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_src;
        logic                      reg_write;
        logic [REG_ADDR_WIDTH-1:0] wreg;
    } exmem_t;

    typedef struct packed {
        logic                      reg_src;
        logic                      reg_write;
        logic [REG_ADDR_WIDTH-1:0] wreg;
    } memwb_t;

    idex_t  dec;
    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;
    logic   reads_rt;
    logic   stall;

    // Opcode decode; unknown opcodes become a NOP with every control bit clear.
    always_comb begin
        dec      = '0;
        reads_rt = 1'b0;
        case (id_opcode)
            OP_LW: begin
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                reads_rt      = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op    = 2'b01;
                dec.branch    = 1'b1;
                reads_rt      = 1'b1;
            end
            OP_BNE: begin
                dec.alu_op    = 2'b01;
                dec.branch_ne = 1'b1;
                reads_rt      = 1'b1;
            end
            OP_R: begin
                dec.alu_op    = 2'b10;
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                reads_rt      = 1'b1;
            end
            default: ;
        endcase
        dec.wreg = dec.reg_dst ? id_rd : id_rt;
    end

    // Hazard and branch resolution; a taken branch overrides a stall so the
    // redirect target is fetched instead of holding the PC.
    always_comb begin
        stall = HAZARD_EN && idex_q.mem_read && (idex_q.wreg != '0) &&
                ((idex_q.wreg == id_rs) || (reads_rt && (idex_q.wreg == id_rt)));
        branch_taken = (exmem_q.branch & mem_zero) | (exmem_q.branch_ne & ~mem_zero);
        ifid_flush   = branch_taken;
        pc_write     = ~stall | branch_taken;
        ifid_write   = ~stall | branch_taken;
    end

    // Next-state for the three control registers (bubble / flush insertion).
    always_comb begin
        idex_d            = (branch_taken || stall) ? '0 : dec;
        exmem_d           = '0;
        if (!branch_taken) begin
            exmem_d.branch    = idex_q.branch;
            exmem_d.branch_ne = idex_q.branch_ne;
            exmem_d.mem_read  = idex_q.mem_read;
            exmem_d.mem_write = idex_q.mem_write;
            exmem_d.reg_src   = idex_q.reg_src;
            exmem_d.reg_write = idex_q.reg_write;
            exmem_d.wreg      = idex_q.wreg;
        end
        memwb_d.reg_src   = exmem_q.reg_src;
        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.wreg      = exmem_q.wreg;
    end

    // Pipeline control registers; reset drops all in-flight control at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_reg_dst    = idex_q.reg_dst;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_wreg       = idex_q.wreg;
    assign mem_branch    = exmem_q.branch;
    assign mem_branch_ne = exmem_q.branch_ne;
    assign mem_read      = exmem_q.mem_read;
    assign mem_write     = exmem_q.mem_write;
    assign mem_wreg      = exmem_q.wreg;
    assign wb_reg_src    = memwb_q.reg_src;
    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_wreg       = memwb_q.wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: one instance with hazard logic, one without.
// Stimulus pushes expected outputs from a stage-list model; a negedge monitor
// pops and compares.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       reg_dst, alu_src;
        logic [1:0] alu_op;
        logic       br, bne, mrd, mwr, rsrc, rwr;
        logic [4:0] wreg;
    } cw_t;

    typedef struct packed {
        logic [8:0] e_ex;
        logic [8:0] e_mem;
        logic [6:0] e_wb;
        logic [3:0] e_ctl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] id_opcode = 6'h3F;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       mem_zero = 1'b0;

    logic       a_reg_dst, a_alu_src, a_br, a_bne, a_mrd, a_mwr, a_rsrc, a_rwr;
    logic [1:0] a_alu_op;
    logic [4:0] a_exw, a_memw, a_wbw;
    logic       a_pcw, a_ifw, a_fl, a_tk;
    logic       b_reg_dst, b_alu_src, b_br, b_bne, b_mrd, b_mwr, b_rsrc, b_rwr;
    logic [1:0] b_alu_op;
    logic [4:0] b_exw, b_memw, b_wbw;
    logic       b_pcw, b_ifw, b_fl, b_tk;

    ctrl_pipe #(.OPCODE_WIDTH(6), .REG_ADDR_WIDTH(5), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .mem_zero(mem_zero),
        .ex_reg_dst(a_reg_dst), .ex_alu_src(a_alu_src), .ex_alu_op(a_alu_op),
        .mem_branch(a_br), .mem_branch_ne(a_bne), .mem_read(a_mrd), .mem_write(a_mwr),
        .wb_reg_src(a_rsrc), .wb_reg_write(a_rwr),
        .ex_wreg(a_exw), .mem_wreg(a_memw), .wb_wreg(a_wbw),
        .pc_write(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_fl), .branch_taken(a_tk));

    ctrl_pipe #(.OPCODE_WIDTH(6), .REG_ADDR_WIDTH(5), .HAZARD_EN(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .mem_zero(mem_zero),
        .ex_reg_dst(b_reg_dst), .ex_alu_src(b_alu_src), .ex_alu_op(b_alu_op),
        .mem_branch(b_br), .mem_branch_ne(b_bne), .mem_read(b_mrd), .mem_write(b_mwr),
        .wb_reg_src(b_rsrc), .wb_reg_write(b_rwr),
        .ex_wreg(b_exw), .mem_wreg(b_memw), .wb_wreg(b_wbw),
        .pc_write(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_fl), .branch_taken(b_tk));

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    cw_t  st [0:1][0:2];   // [instance][EX, MEM, WB] contents of the model pipeline

    // Control word straight from the opcode table.
    function automatic cw_t decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        cw_t c = '0;
        case (op)
            6'h23: begin c.alu_src = 1; c.mrd = 1; c.rsrc = 1; c.rwr = 1; end
            6'h2B: begin c.alu_src = 1; c.mwr = 1; end
            6'h08: begin c.alu_src = 1; c.rwr = 1; end
            6'h04: begin c.alu_op = 2'b01; c.br = 1; end
            6'h05: begin c.alu_op = 2'b01; c.bne = 1; end
            6'h00: begin c.alu_op = 2'b10; c.reg_dst = 1; c.rwr = 1; end
            default: ;
        endcase
        c.wreg = c.reg_dst ? rd : rt;
        return c;
    endfunction

    // One cycle of the reference: expected outputs now, then advance the stages.
    task automatic model(input int h, input bit in_rst, output exp_t e);
        cw_t ex, mm, wb;
        bit  taken, hz, rrt;
        if (in_rst) begin st[h][0] = '0; st[h][1] = '0; st[h][2] = '0; end
        ex = st[h][0]; mm = st[h][1]; wb = st[h][2];
        taken = (mm.br && mem_zero) || (mm.bne && !mem_zero);
        rrt   = (id_opcode == 6'h00) || (id_opcode == 6'h2B) ||
                (id_opcode == 6'h04) || (id_opcode == 6'h05);
        hz    = (h == 0) && ex.mrd && (ex.wreg != 0) &&
                ((ex.wreg == id_rs) || (rrt && ex.wreg == id_rt));
        e.e_ex  = {ex.reg_dst, ex.alu_src, ex.alu_op, ex.wreg};
        e.e_mem = {mm.br, mm.bne, mm.mrd, mm.mwr, mm.wreg};
        e.e_wb  = {wb.rsrc, wb.rwr, wb.wreg};
        e.e_ctl = {(!hz || taken), (!hz || taken), taken, taken};
        st[h][2] = mm;
        st[h][1] = taken ? '0 : ex;
        st[h][0] = (taken || hz) ? '0 : decode(id_opcode, id_rt, id_rd);
    endtask

    // Apply one instruction for one cycle; optionally pulse reset for half a cycle.
    task automatic cyc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z, input bit rst = 1'b0);
        exp_t ea, eb;
        @(posedge clk); #1;
        id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; mem_zero = z;
        if (rst) rst_n = 1'b0;
        model(0, rst, ea); q_a.push_back(ea);
        model(1, rst, eb); q_b.push_back(eb);
        if (rst) begin @(negedge clk); #1; rst_n = 1'b1; end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, so pop whenever an entry waits.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("ex",   16'({a_reg_dst, a_alu_src, a_alu_op, a_exw}), 16'(e.e_ex));
            chk("mem",  16'({a_br, a_bne, a_mrd, a_mwr, a_memw}),     16'(e.e_mem));
            chk("wb",   16'({a_rsrc, a_rwr, a_wbw}),                  16'(e.e_wb));
            chk("ctl",  16'({a_pcw, a_ifw, a_fl, a_tk}),              16'(e.e_ctl));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("nh_ex",  16'({b_reg_dst, b_alu_src, b_alu_op, b_exw}), 16'(e.e_ex));
            chk("nh_mem", 16'({b_br, b_bne, b_mrd, b_mwr, b_memw}),     16'(e.e_mem));
            chk("nh_wb",  16'({b_rsrc, b_rwr, b_wbw}),                  16'(e.e_wb));
            chk("nh_ctl", 16'({b_pcw, b_ifw, b_fl, b_tk}),              16'(e.e_ctl));
        end
    end

    localparam logic [5:0] R = 6'h00, BEQ = 6'h04, BNE = 6'h05, ADDI = 6'h08,
                           LW = 6'h23, SW = 6'h2B, NOP = 6'h3F;

    initial begin
        logic [5:0] ops [0:7];
        ops[0] = R; ops[1] = BEQ; ops[2] = BNE; ops[3] = ADDI;
        ops[4] = LW; ops[5] = SW; ops[6] = NOP; ops[7] = 6'h11;

        repeat (2) @(posedge clk);
        cyc(NOP, 0, 0, 0, 0, 1'b1);                 // reset state
        // decode table and write-back timing
        cyc(ADDI, 1, 2, 3, 0);
        cyc(R,    1, 2, 4, 0);
        cyc(SW,   1, 6, 0, 0);
        cyc(NOP,  0, 0, 0, 0);
        repeat (3) cyc(NOP, 0, 0, 0, 0);
        // load-use stall; IF/ID holds the R-type for a second cycle
        cyc(LW, 1, 5, 0, 0);
        cyc(R,  5, 2, 9, 0);
        cyc(R,  5, 2, 9, 0);
        repeat (3) cyc(NOP, 0, 0, 0, 0);
        // no-stall cases: rt=0 load, ADDI does not read rt
        cyc(LW, 1, 0, 0, 0);
        cyc(R,  0, 0, 4, 0);
        cyc(LW, 1, 7, 0, 0);
        cyc(ADDI, 3, 7, 0, 0);
        repeat (3) cyc(NOP, 0, 0, 0, 0);
        // BEQ taken, then not taken
        cyc(BEQ, 1, 2, 0, 1);
        repeat (3) cyc(ADDI, 1, 3, 0, 1);
        cyc(BEQ, 1, 2, 0, 0);
        repeat (3) cyc(ADDI, 1, 3, 0, 0);
        // BNE taken in MEM while a load-use is pending in ID
        cyc(BNE, 1, 2, 0, 0);
        cyc(LW,  1, 8, 0, 0);
        cyc(R,   8, 2, 4, 0);
        repeat (3) cyc(NOP, 0, 0, 0, 0);
        // reset mid-stream
        cyc(ADDI, 1, 2, 0, 0);
        cyc(R,    1, 2, 4, 0);
        cyc(SW,   1, 3, 0, 0);
        cyc(NOP,  0, 0, 0, 0, 1'b1);
        repeat (4) cyc(NOP, 0, 0, 0, 0);
        // randomized traffic with small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(0, 63));
            cyc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) == 0));
        end
        @(negedge clk); #1;
        n_chk++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
